// File: rtl/mem_wb_stage_if.sv
// Signal bundle between the EX/ID stages and the MEM/WB pipeline stage.
interface mem_wb_stage_if;
  logic        ex_valid;
  logic [15:0] ex_alu_out;
  logic [15:0] ex_store_data;
  logic [1:0]  ex_wr;
  logic        ex_reg_write;
  logic        ex_mem_read;
  logic        ex_mem_write;
  logic        ex_mem_to_reg;
  logic [1:0]  id_rs;
  logic [1:0]  id_rt;
  logic [1:0]  wb_wr;
  logic [15:0] wb_wd;
  logic        wb_reg_write;
  logic        misalign;
  logic [1:0]  fwd_a;
  logic [1:0]  fwd_b;
  logic [15:0] fwd_mem_data;

  modport master (
    output ex_valid, ex_alu_out, ex_store_data, ex_wr, ex_reg_write,
           ex_mem_read, ex_mem_write, ex_mem_to_reg, id_rs, id_rt,
    input  wb_wr, wb_wd, wb_reg_write, misalign, fwd_a, fwd_b, fwd_mem_data
  );

  modport slave (
    input  ex_valid, ex_alu_out, ex_store_data, ex_wr, ex_reg_write,
           ex_mem_read, ex_mem_write, ex_mem_to_reg, id_rs, id_rt,
    output wb_wr, wb_wd, wb_reg_write, misalign, fwd_a, fwd_b, fwd_mem_data
  );
endinterface

// File: rtl/mem_wb_stage.sv
// EXMEM/MEMWB pipeline registers with a 256x16 data memory, clocked on the falling edge.
// Define MEMWB_FWD_EN to build the MEM/WB forwarding selects; otherwise they tie to zero.
module mem_wb_stage (
  input logic           clock,
  input logic           reset_n,
  mem_wb_stage_if.slave bus
);
  logic        exm_valid;
  logic [15:0] exm_alu_out;
  logic [15:0] exm_store_data;
  logic [1:0]  exm_wr;
  logic        exm_reg_write;
  logic        exm_mem_read;
  logic        exm_mem_write;
  logic        exm_mem_to_reg;

  logic [1:0]  mwb_wr;
  logic [15:0] mwb_wd;
  logic        mwb_reg_write;

  // 2-state storage so contents start at zero; reset never touches it.
  bit   [15:0] dmem [256];
  logic [7:0]  word_idx;
  logic [15:0] rd_data;
  logic [15:0] mem_result;

  assign word_idx   = exm_alu_out[8:1];
  assign rd_data    = dmem[word_idx];
  assign mem_result = exm_mem_to_reg ? rd_data : exm_alu_out;

  always_ff @(negedge clock or negedge reset_n) begin
    if (!reset_n) begin
      exm_valid      <= 1'b0;
      exm_alu_out    <= '0;
      exm_store_data <= '0;
      exm_wr         <= '0;
      exm_reg_write  <= 1'b0;
      exm_mem_read   <= 1'b0;
      exm_mem_write  <= 1'b0;
      exm_mem_to_reg <= 1'b0;
      mwb_wr         <= '0;
      mwb_wd         <= '0;
      mwb_reg_write  <= 1'b0;
    end else begin
      exm_valid      <= bus.ex_valid;
      exm_alu_out    <= bus.ex_alu_out;
      exm_store_data <= bus.ex_store_data;
      exm_wr         <= bus.ex_wr;
      exm_reg_write  <= bus.ex_reg_write;
      exm_mem_read   <= bus.ex_mem_read;
      exm_mem_write  <= bus.ex_mem_write;
      exm_mem_to_reg <= bus.ex_mem_to_reg;
      mwb_wr         <= exm_wr;
      mwb_wd         <= mem_result;
      // A combined read+write request performs only the store.
      mwb_reg_write  <= exm_valid & exm_reg_write & (exm_wr != '0)
                        & ~(exm_mem_read & exm_mem_write);
    end
  end

  // Reset clears exm_valid asynchronously, so a store caught in EXMEM is dropped.
  always_ff @(negedge clock) begin
    if (reset_n && exm_valid && exm_mem_write)
      dmem[word_idx] <= exm_store_data;
  end

  assign bus.wb_wr        = mwb_wr;
  assign bus.wb_wd        = mwb_wd;
  assign bus.wb_reg_write = mwb_reg_write;
  assign bus.misalign     = exm_valid & (exm_mem_read | exm_mem_write) & exm_alu_out[0];

`ifdef MEMWB_FWD_EN
  logic mem_prod;

  assign mem_prod = exm_valid & exm_reg_write & (exm_wr != '0);

  always_comb begin
    bus.fwd_a = 2'b00;
    if (mem_prod && (exm_wr == bus.id_rs))
      bus.fwd_a = 2'b01;
    else if (mwb_reg_write && (mwb_wr == bus.id_rs))
      bus.fwd_a = 2'b10;

    bus.fwd_b = 2'b00;
    if (mem_prod && (exm_wr == bus.id_rt))
      bus.fwd_b = 2'b01;
    else if (mwb_reg_write && (mwb_wr == bus.id_rt))
      bus.fwd_b = 2'b10;
  end

  assign bus.fwd_mem_data = mem_result;
`else
  logic unused_id;

  assign unused_id        = ^{bus.id_rs, bus.id_rt};
  assign bus.fwd_a        = '0;
  assign bus.fwd_b        = '0;
  assign bus.fwd_mem_data = '0;
`endif
endmodule

// File: tb/tb_mem_wb_stage.sv
// Scoreboard bench for mem_wb_stage: program-order reference model, decoupled monitor.
module tb_mem_wb_stage;
  logic clock = 1'b0;
  logic reset_n;

  mem_wb_stage_if bus ();

  mem_wb_stage dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clock = ~clock;

  typedef struct {
    int          tag;
    logic [1:0]  wr;
    logic [15:0] wd;
    logic        rw;
    logic        mis;
    logic        prod;
    logic        st;
    logic [7:0]  st_idx;
    logic [15:0] st_old;
  } rec_t;

  logic [15:0] model_mem [256];
  rec_t        wb_q[$];
  rec_t        mem_q[$];
  rec_t        mrec, wrec, bubble;
  int          ecnt   = 0;
  int          errors = 0;
  int          checks = 0;
  bit          mon_en = 1'b0;
  logic [1:0]  cur_rs, cur_rt;
  logic [1:0]  ea, eb;
  logic [15:0] emd;

  always @(negedge clock) ecnt++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_zero(input string name);
    chk({name, "_wb"}, 32'({bus.wb_wr, bus.wb_wd, bus.wb_reg_write}), 32'd0);
    chk({name, "_mis"}, 32'(bus.misalign), 32'd0);
    chk({name, "_fwd"}, 32'({bus.fwd_a, bus.fwd_b, bus.fwd_mem_data}), 32'd0);
  endtask

  // Executes one instruction in program order and records what the pipeline must show.
  task automatic drive_push(input logic v, input logic [15:0] alu, input logic [15:0] sd,
                            input logic [1:0] wr, input logic rw, input logic mr,
                            input logic mw, input logic m2r, input logic [1:0] rs,
                            input logic [1:0] rt);
    rec_t        r;
    logic [7:0]  idx;
    logic [15:0] rd;
    bus.ex_valid = v;       bus.ex_alu_out = alu;    bus.ex_store_data = sd;
    bus.ex_wr = wr;         bus.ex_reg_write = rw;   bus.ex_mem_read = mr;
    bus.ex_mem_write = mw;  bus.ex_mem_to_reg = m2r; bus.id_rs = rs;
    bus.id_rt = rt;         cur_rs = rs;             cur_rt = rt;
    idx      = alu[8:1];
    rd       = model_mem[idx];
    r.tag    = ecnt + 1;
    r.wr     = wr;
    r.wd     = m2r ? rd : alu;
    r.rw     = v && rw && (wr != 2'd0) && !(mr && mw);
    r.mis    = v && (mr || mw) && alu[0];
    r.prod   = v && rw && (wr != 2'd0);
    r.st     = v && mw;
    r.st_idx = idx;
    r.st_old = rd;
    if (r.st) model_mem[idx] = sd;
    wb_q.push_back(r);
    mem_q.push_back(r);
  endtask

  task automatic issue(input logic v, input logic [15:0] alu, input logic [15:0] sd,
                       input logic [1:0] wr, input logic rw, input logic mr,
                       input logic mw, input logic m2r, input logic [1:0] rs,
                       input logic [1:0] rt);
    @(posedge clock);
    #1;
    drive_push(v, alu, sd, wr, rw, mr, mw, m2r, rs, rt);
  endtask

  task automatic idle(input logic [1:0] rs, input logic [1:0] rt);
    issue(1'b0, 16'd0, 16'd0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, rs, rt);
  endtask

  task automatic rand_issue();
    logic        v, rw, mr, mw, m2r;
    logic [15:0] alu;
    v   = ($urandom_range(0, 3) != 0);
    alu = ($urandom_range(0, 1) == 1) ? 16'($urandom_range(0, 31)) : 16'($urandom);
    mr  = ($urandom_range(0, 2) == 0);
    mw  = ($urandom_range(0, 2) == 0);
    m2r = mr ? 1'b1 : ($urandom_range(0, 3) == 0);
    rw  = ($urandom_range(0, 3) != 0);
    issue(v, alu, 16'($urandom), 2'($urandom), rw, mr, mw, m2r, 2'($urandom), 2'($urandom));
  endtask

  task automatic release_reset();
    @(posedge clock);
    #1;
    bubble = '{default: '0};
    bubble.tag = ecnt;
    wb_q.push_back(bubble);
    reset_n = 1'b1;
    drive_push(1'b0, 16'd0, 16'd0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0);
    mon_en = 1'b1;
  endtask

  // Called just after an issue: asserts reset between edges and undoes uncommitted stores.
  task automatic reset_midstream();
    #1;
    reset_n = 1'b0;
    mon_en  = 1'b0;
    #1;
    check_zero("rst_async");
    for (int i = wb_q.size() - 1; i >= 0; i--)
      if (wb_q[i].st && wb_q[i].tag >= ecnt) model_mem[wb_q[i].st_idx] = wb_q[i].st_old;
    wb_q.delete();
    mem_q.delete();
    repeat (2) begin
      @(posedge clock);
      #1;
      bus.ex_valid = 1'b1;      bus.ex_mem_write = 1'b1;  bus.ex_alu_out = 16'h0020;
      bus.ex_store_data = 16'($urandom); bus.ex_reg_write = 1'b1; bus.ex_wr = 2'd1;
    end
    @(posedge clock);
    #1;
    check_zero("rst_hold");
    release_reset();
  endtask

  always @(posedge clock) begin
    if (mon_en) begin
      if (wb_q.size() == 0 || mem_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL scoreboard_empty wb_q=%0d mem_q=%0d expected entries", wb_q.size(), mem_q.size());
      end else begin
        wrec = wb_q.pop_front();
        mrec = mem_q.pop_front();
        chk("sb_tag", 32'({wrec.tag[15:0], mrec.tag[15:0]}),
            32'({16'(ecnt - 1), 16'(ecnt)}));
        chk("wb", 32'({bus.wb_wr, bus.wb_wd, bus.wb_reg_write}),
            32'({wrec.wr, wrec.wd, wrec.rw}));
        chk("misalign", 32'(bus.misalign), 32'(mrec.mis));
`ifdef MEMWB_FWD_EN
        ea  = (mrec.prod && mrec.wr == cur_rs) ? 2'b01 : (wrec.rw && wrec.wr == cur_rs) ? 2'b10 : 2'b00;
        eb  = (mrec.prod && mrec.wr == cur_rt) ? 2'b01 : (wrec.rw && wrec.wr == cur_rt) ? 2'b10 : 2'b00;
        emd = mrec.wd;
`else
        ea  = 2'b00;
        eb  = 2'b00;
        emd = 16'd0;
`endif
        chk("fwd", 32'({bus.fwd_a, bus.fwd_b, bus.fwd_mem_data}), 32'({ea, eb, emd}));
      end
    end
  end

  initial begin
    for (int i = 0; i < 256; i++) model_mem[i] = 16'd0;
    reset_n = 1'b0;
    bus.ex_valid = 1'b0;      bus.ex_alu_out = 16'd0;   bus.ex_store_data = 16'd0;
    bus.ex_wr = 2'd0;         bus.ex_reg_write = 1'b0;  bus.ex_mem_read = 1'b0;
    bus.ex_mem_write = 1'b0;  bus.ex_mem_to_reg = 1'b0; bus.id_rs = 2'd0;
    bus.id_rt = 2'd0;
    #1;
    check_zero("rst_init");
    repeat (2) @(posedge clock);
    release_reset();

    // ALU pass-through, then the same with wr=0
    issue(1'b1, 16'd22, 16'd0, 2'd3, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0);
    issue(1'b1, 16'd22, 16'd0, 2'd0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0);
    // store then back-to-back load of the same word
    issue(1'b1, 16'h0010, 16'h1234, 2'd0, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 2'd0);
    issue(1'b1, 16'h0010, 16'h0000, 2'd2, 1'b1, 1'b1, 1'b0, 1'b1, 2'd0, 2'd0);
    // misaligned store wrapping onto word 8, later load of 0x0010
    issue(1'b1, 16'h0211, 16'hBEEF, 2'd0, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 2'd0);
    idle(2'd0, 2'd0);
    issue(1'b1, 16'h0010, 16'h0000, 2'd3, 1'b1, 1'b1, 1'b0, 1'b1, 2'd0, 2'd0);
    // read+write together: only the store lands, no writeback
    issue(1'b1, 16'h0040, 16'h4242, 2'd1, 1'b1, 1'b1, 1'b1, 1'b1, 2'd0, 2'd0);
    issue(1'b1, 16'h0040, 16'h0000, 2'd1, 1'b1, 1'b1, 1'b0, 1'b1, 2'd0, 2'd0);
    // forwarding: WB holds wr1=7, MEM holds wr1=15, ID asks rs=1 rt=2
    issue(1'b1, 16'd7, 16'd0, 2'd1, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0);
    issue(1'b1, 16'd15, 16'd0, 2'd1, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0);
    idle(2'd1, 2'd2);
    idle(2'd1, 2'd1);
    // store caught in EXMEM by reset must not land
    issue(1'b1, 16'h0020, 16'h5555, 2'd0, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 2'd0);
    idle(2'd0, 2'd0);
    issue(1'b1, 16'h0020, 16'hAAAA, 2'd0, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 2'd0);
    idle(2'd0, 2'd0);
    reset_midstream();
    issue(1'b1, 16'h0020, 16'h0000, 2'd1, 1'b1, 1'b1, 1'b0, 1'b1, 2'd0, 2'd0);
    idle(2'd0, 2'd0);

    for (int n = 0; n < 300; n++) begin
      rand_issue();
      if (n == 150) begin
        idle(2'd0, 2'd0);
        reset_midstream();
      end
    end
    repeat (3) idle(2'd0, 2'd0);
    @(posedge clock);
    #1;
    mon_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/mem_wb_stage.md
MEM_WB_STAGE -- requirements
Module: mem_wb_stage

Interface
REQ-001 The block SHALL have these ports, listed as name, direction, width, meaning:
- clock  in  1  sole clock; all state updates on its falling edge
- reset_n  in  1  asynchronous, active-low reset
- ex_valid  in  1  EX-stage result valid this cycle
- ex_alu_out  in  16  ALU result; also the byte address for loads and stores
- ex_store_data  in  16  store data (forwarded RD2)
- ex_wr  in  2  destination register
- ex_reg_write  in  1  register write enable
- ex_mem_read  in  1  load
- ex_mem_write  in  1  store
- ex_mem_to_reg  in  1  writeback selects memory data instead of the ALU result
- id_rs  in  2  ID-stage source register 1
- id_rt  in  2  ID-stage source register 2
- wb_wr  out  2  writeback register
- wb_wd  out  16  writeback data
- wb_reg_write  out  1  writeback enable
- misalign  out  1  MEM-stage access with address bit 0 set
- fwd_a  out  2  forward select for rs: 00 none, 01 MEM, 10 WB
- fwd_b  out  2  forward select for rt, same encoding
- fwd_mem_data  out  16  MEM-stage result for forwarding

Function
REQ-002 The EXMEM register SHALL capture all ex_* inputs on each falling edge of clock; when ex_valid=0 it SHALL capture valid=0.
REQ-003 Data memory SHALL be 256 x 16 bits, word index = EXMEM address[8:1]; address bits 15:9 are ignored, so addresses wrap every 512 bytes.
REQ-004 A store SHALL write the EXMEM store data on the falling edge that ends its MEM cycle, when EXMEM valid=1 and mem_write=1.
REQ-005 A load SHALL read memory combinationally from the EXMEM address during the MEM cycle.
REQ-006 misalign SHALL equal EXMEM valid & (mem_read | mem_write) & address[0]; the access still proceeds using address[8:1].
REQ-007 If mem_read and mem_write are both set, only the write SHALL occur, and the MEMWB reg_write SHALL be captured as 0.
REQ-008 The MEMWB register SHALL capture, on the falling edge:
- wr
- data = mem_to_reg ? memory read data : ALU result
- reg_write = valid & reg_write & (wr != 0)
REQ-009 wb_wr, wb_wd and wb_reg_write SHALL be driven directly from the MEMWB register.
REQ-010 Latency SHALL be as follows, for an input presented before falling edge N:
- EXMEM holds it after edge N
- a store commits at edge N+1
- wb_* is valid after edge N+1
REQ-011 A load immediately following a store to the same word SHALL return the newly stored value, with no stall.
REQ-012 Memory contents SHALL be zero at time 0 and SHALL NOT be affected by reset.

Reset
REQ-013 While reset_n=0, the following SHALL be 0: EXMEM valid, MEMWB reg_write, all pipeline data and register fields, and all outputs.
REQ-014 Reset SHALL take effect immediately, without waiting for a clock edge.
REQ-015 A store held in EXMEM when reset asserts SHALL be dropped, leaving memory unchanged.
REQ-016 The first capture after reset release SHALL occur on the next falling edge.

Configuration
REQ-017 The macro MEMWB_FWD_EN SHALL compile the forwarding logic in or out.
REQ-018 With MEMWB_FWD_EN defined:
- fwd_mem_data = EXMEM mem_to_reg ? memory read data : ALU result
- fwd_a = 01 when EXMEM valid & reg_write & wr != 0 & wr == id_rs
- otherwise fwd_a = 10 when wb_reg_write & wb_wr == id_rs
- otherwise fwd_a = 00
- the MEM match takes priority over the WB match
- fwd_b follows the same rules using id_rt
REQ-019 Without MEMWB_FWD_EN, fwd_a, fwd_b and fwd_mem_data SHALL be constant 0, and no comparator logic SHALL be synthesized.

Verification
REQ-020 Reset: hold reset_n=0 mid-stream -> all outputs 0 immediately; release -> wb_reg_write=0 until the first valid instruction reaches WB.
REQ-021 ALU pass-through: ex_alu_out=22, ex_wr=3, ex_reg_write=1 -> after two falling edges, wb_wd=22, wb_wr=3, wb_reg_write=1. Repeat with ex_wr=0 -> wb_reg_write=0.
REQ-022 Store then load: store 16'h1234 to address 0x0010, then on the next cycle load address 0x0010 with ex_wr=2 and ex_mem_to_reg=1 -> wb_wd=16'h1234 and wb_wr=2 two edges after the load is presented.
REQ-023 Misaligned access and wrap: store 16'hBEEF to address 0x0211 -> misalign=1 during the MEM cycle; a later load from address 0x0010 returns 16'hBEEF.
REQ-024 Forwarding (MEMWB_FWD_EN defined): EXMEM holds wr=1 with ALU result 15, MEMWB holds wr=1 with data 7, id_rs=1, id_rt=2 -> fwd_a=01, fwd_b=00, fwd_mem_data=15. The same stimulus without the macro -> all three outputs 0.
REQ-025 Reset during a store: a store to address 0x0020 is in EXMEM and reset_n falls before the edge -> a later load from 0x0020 returns the prior value.
